mem_arbiter: RTL and testbench

Two-requester arbiter sharing one memory port between the instruction fetch unit (IFU) and the load/store unit (LSU) in the npc core. It accepts one request at a time, holds it until the memory side accepts, waits for the response, and routes that response back to the requester that issued it. The downstream memory port feeds the DPI-backed memory model. Only one transaction is outstanding at any time.

---
 rtl/mem_arbiter.sv | 82 ++++++++
 tb/tb_mem_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU and LSU, one transaction outstanding.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ifu_req_*/ifu_addr       IFU read request (valid/ready handshake)
//   ifu_resp_valid/rdata     one-cycle IFU response
//   lsu_req_*/lsu_we/addr/wdata/wmask  LSU read/write request
//   lsu_resp_valid/rdata     one-cycle LSU response (rdata 0 on writes)
//   mem_req_*/mem_we/addr/wdata/wmask  registered request to memory
//   mem_resp_valid/rdata     memory response
//   busy                     high whenever not IDLE
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_we,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t state, state_n;
    logic last_grant, owner;
    logic grant_lsu, accept, resp;
    always_comb begin
        grant_lsu      = lsu_req_valid && (!ifu_req_valid || !last_grant);
        ifu_req_ready  = !rst && state == IDLE && ifu_req_valid && !grant_lsu;
        lsu_req_ready  = !rst && state == IDLE && grant_lsu;
        accept         = ifu_req_ready || lsu_req_ready;
        resp           = state == RESP && mem_resp_valid;
        state_n        = state == IDLE ? (accept ? REQ : IDLE) :
                         state == REQ  ? (mem_req_ready ? RESP : REQ) :
                                         (mem_resp_valid ? IDLE : RESP);
        mem_req_valid  = state == REQ;
        busy           = state != IDLE;
        ifu_resp_valid = resp && !owner;
        lsu_resp_valid = resp && owner;
        ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
        lsu_rdata      = lsu_resp_valid && !mem_we ? mem_rdata : '0;
    end
    // last_grant/owner: 1 = LSU, 0 = IFU
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            owner      <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                owner      <= grant_lsu;
                last_grant <= grant_lsu;
                mem_we     <= grant_lsu && lsu_we;
                mem_addr   <= grant_lsu ? lsu_addr : ifu_addr;
                mem_wdata  <= grant_lsu ? lsu_wdata : '0;
                mem_wmask  <= grant_lsu ? lsu_wmask : '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter.
// Ports: none (drives every mem_arbiter port, inputs change on negedge).
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid = 1'b0, ifu_req_ready;
    logic [63:0] ifu_addr = '0;
    logic        ifu_resp_valid;
    logic [63:0] ifu_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_we = 1'b0;
    logic [63:0] lsu_addr = '0, lsu_wdata = '0;
    logic [7:0]  lsu_wmask = '0;
    logic        lsu_resp_valid;
    logic [63:0] lsu_rdata;
    logic        mem_req_valid, mem_req_ready = 1'b0, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        busy;
    int vectors = 0, errs = 0;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mrv"}, mem_req_valid, 0);
        chk({tag, "_rdy"}, {ifu_req_ready, lsu_req_ready}, 0);
        chk({tag, "_resp"}, {ifu_resp_valid, lsu_resp_valid}, 0);
        chk({tag, "_rdata"}, ifu_rdata | lsu_rdata, 0);
    endtask

    task automatic ifu_read(input string tag, input logic [63:0] a, input logic [63:0] d);
        @(negedge clk); ifu_req_valid = 1; ifu_addr = a; mem_req_ready = 1; #1;
        chk({tag, "_ifu_rdy"}, ifu_req_ready, 1);
        chk({tag, "_lsu_rdy"}, lsu_req_ready, 0);
        @(negedge clk); ifu_req_valid = 0; #1;
        chk({tag, "_mrv"}, mem_req_valid, 1);
        chk({tag, "_maddr"}, mem_addr, a);
        chk({tag, "_mwe"}, mem_we, 0);
        chk({tag, "_mwmask"}, mem_wmask, 0);
        chk({tag, "_busy"}, busy, 1);
        @(negedge clk); mem_resp_valid = 1; mem_rdata = d; #1;
        chk({tag, "_ifu_resp"}, ifu_resp_valid, 1);
        chk({tag, "_ifu_rdata"}, ifu_rdata, d);
        chk({tag, "_lsu_resp"}, lsu_resp_valid, 0);
        @(negedge clk); mem_resp_valid = 0; #1;
        chk_idle_outputs({tag, "_after"});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1 chk_idle_outputs("reset");
        chk("reset_maddr", mem_addr | mem_wdata, 0);
        chk("reset_mwe", {mem_we, mem_wmask}, 0);
        @(negedge clk); rst = 0;

        ifu_read("ifu_read", 64'h8000_0000, 64'h0000_0413_0000_0297);

        @(negedge clk);
        lsu_req_valid = 1; lsu_we = 1; lsu_addr = 64'h8000_1000;
        lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F; #1;
        chk("wr_lsu_rdy", lsu_req_ready, 1);
        chk("wr_ifu_rdy", ifu_req_ready, 0);
        @(negedge clk); lsu_req_valid = 0; #1;
        chk("wr_mrv", mem_req_valid, 1);
        chk("wr_mwe", mem_we, 1);
        chk("wr_maddr", mem_addr, 64'h8000_1000);
        chk("wr_mwdata", mem_wdata, 64'hDEAD_BEEF);
        chk("wr_mwmask", mem_wmask, 8'h0F);
        @(negedge clk); mem_resp_valid = 1; mem_rdata = 64'h1234_5678; #1;
        chk("wr_lsu_resp", lsu_resp_valid, 1);
        chk("wr_lsu_rdata", lsu_rdata, 0);
        chk("wr_ifu_resp", ifu_resp_valid, 0);
        @(negedge clk); mem_resp_valid = 0; #1;
        chk_idle_outputs("wr_after");

        @(negedge clk); rst = 1; #1;
        chk_idle_outputs("tie_reset");
        @(negedge clk);
        rst = 0; lsu_we = 0; ifu_req_valid = 1; lsu_req_valid = 1;
        ifu_addr = 64'h8000_0010; lsu_addr = 64'h8000_2000;
        mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 64'hA5A5;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk($sformatf("tie%0d_lsu_rdy", g), lsu_req_ready, (g % 2 == 0));
            chk($sformatf("tie%0d_ifu_rdy", g), ifu_req_ready, (g % 2 == 1));
            @(negedge clk); #1;
            chk($sformatf("tie%0d_req_rdy", g), {ifu_req_ready, lsu_req_ready}, 0);
            chk($sformatf("tie%0d_req_resp", g), {ifu_resp_valid, lsu_resp_valid}, 0);
            @(negedge clk); #1;
            chk($sformatf("tie%0d_resp_rdy", g), {ifu_req_ready, lsu_req_ready}, 0);
            chk($sformatf("tie%0d_resp_who", g), {ifu_resp_valid, lsu_resp_valid}, (g % 2 == 0) ? 2'b01 : 2'b10);
            @(negedge clk);
        end
        ifu_req_valid = 0; lsu_req_valid = 0; mem_resp_valid = 0;

        lsu_req_valid = 1; lsu_addr = 64'h8000_3000; mem_req_ready = 0; #1;
        chk("bp_lsu_rdy", lsu_req_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); lsu_req_valid = 0; ifu_req_valid = 1; #1;
            chk($sformatf("bp%0d_mrv", i), mem_req_valid, 1);
            chk($sformatf("bp%0d_maddr", i), mem_addr, 64'h8000_3000);
            chk($sformatf("bp%0d_mwe", i), mem_we, 0);
            chk($sformatf("bp%0d_rdy", i), {ifu_req_ready, lsu_req_ready}, 0);
        end
        @(negedge clk); mem_req_ready = 1; #1;
        chk("bp6_mrv", mem_req_valid, 1);
        chk("bp6_maddr", mem_addr, 64'h8000_3000);
        @(negedge clk); ifu_req_valid = 0; mem_resp_valid = 1; mem_rdata = 64'hCAFE; #1;
        chk("bp_mrv_low", mem_req_valid, 0);
        chk("bp_lsu_resp", lsu_resp_valid, 1);
        chk("bp_lsu_rdata", lsu_rdata, 64'hCAFE);
        @(negedge clk); mem_resp_valid = 0; #1;
        chk_idle_outputs("bp_after");

        mem_resp_valid = 1; #1;
        chk("stray_idle_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        @(negedge clk); #1;
        chk("stray_idle_busy", busy, 0);
        mem_resp_valid = 0; ifu_req_valid = 1; ifu_addr = 64'h8000_0004; mem_req_ready = 0; #1;
        chk("stray_ifu_rdy", ifu_req_ready, 1);
        @(negedge clk); ifu_req_valid = 0; mem_resp_valid = 1; #1;
        chk("stray_req_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        chk("stray_req_mrv", mem_req_valid, 1);
        @(negedge clk); mem_resp_valid = 0; mem_req_ready = 1; #1;
        chk("stray_still_req", mem_req_valid, 1);
        @(negedge clk); #1;
        chk("stray_resp_state", {busy, mem_req_valid}, 2'b10);

        rst = 1; mem_resp_valid = 1; mem_rdata = 64'hBAD; #1;
        chk_idle_outputs("rst_resp");
        chk("rst_resp_fields", {mem_we, mem_addr, mem_wmask}, 0);
        @(negedge clk); rst = 0; #1;
        chk("rst_late_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        chk("rst_late_busy", busy, 0);
        mem_resp_valid = 0;
        ifu_read("post_rst", 64'h8000_0000, 64'h0000_0413_0000_0297);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
